// File: rtl/srff_bank_arbiter.sv
// Round-robin arbiter that serialises set/clear commands onto a shared SR flop bank.
// Optional SRFF_ARB_SKIP_EN: commands that would not change the flag are acked without an S/R pulse.
//
// state | meaning
// IDLE  | waiting for a request; requests are sampled only here
// GRANT | winner latched, S/R one-hot being prepared
// DRIVE | single-cycle S or R pulse on the addressed flop
// ACK   | one-cycle ack to the winner, pointer advances
module srff_bank_arbiter #(
   parameter int NREQ  = 4,
   parameter int IDX_W = 3,
   localparam int NFLAG = 2 ** IDX_W
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [NREQ-1:0]       req,
   input  logic [NREQ-1:0]       op,
   input  logic [NREQ*IDX_W-1:0] idx,
   output logic [NREQ-1:0]       ack,
   output logic                  busy,
   output logic [NFLAG-1:0]      s_out,
   output logic [NFLAG-1:0]      r_out,
   output logic [NFLAG-1:0]      flag_q,
   output logic                  skipped
);

   localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

   typedef enum logic [1:0] {IDLE, GRANT, DRIVE, ACK} state_t;

   state_t             state, state_n;
   logic [PTR_W-1:0]   rr_ptr, winner, next_ptr, pick, off;
   logic [PTR_W:0]     sum;
   logic [NREQ-1:0]    rot;
   logic               pick_valid;
   logic               op_sel, op_l;
   logic [IDX_W-1:0]   idx_sel, idx_l;
   logic [NFLAG-1:0]   target;
   logic               skip_now;

`ifdef SRFF_ARB_SKIP_EN
   logic skip_q;

   assign skip_now = (flag_q[idx_l] == op_l);

   always_ff @(posedge clk) begin
      if (reset) begin
         skip_q <= 1'b0;
      end else if (state == GRANT) begin
         skip_q <= skip_now;
      end
   end
`else
   assign skip_now = 1'b0;
`endif

   // Rotate requests so the scan always starts at bit 0, then map the offset back.
   always_comb begin
      rot = NREQ'({req, req} >> rr_ptr);
      pick_valid = |rot;
      off = '0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         if (rot[k]) off = PTR_W'(k);
      end
      sum = {1'b0, rr_ptr} + {1'b0, off};
      if (sum >= (PTR_W+1)'(NREQ)) sum = sum - (PTR_W+1)'(NREQ);
      pick = sum[PTR_W-1:0];
   end

   always_comb begin
      op_sel  = 1'b0;
      idx_sel = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (pick == PTR_W'(i)) begin
            op_sel  = op[i];
            idx_sel = idx[i*IDX_W +: IDX_W];
         end
      end
   end

   assign next_ptr = (winner == PTR_W'(NREQ - 1)) ? '0 : winner + 1'b1;
   assign target   = {{(NFLAG-1){1'b0}}, 1'b1} << idx_l;

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_n;
      end
   end

   always_comb begin
      state_n = state;
      case (state)
         IDLE:    if (pick_valid) state_n = GRANT;
         GRANT:   state_n = skip_now ? ACK : DRIVE;
         DRIVE:   state_n = ACK;
         ACK:     state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_comb begin
      ack     = '0;
      busy    = (state != IDLE);
      skipped = 1'b0;
      if (state == ACK) ack[winner] = 1'b1;
`ifdef SRFF_ARB_SKIP_EN
      skipped = (state == ACK) && skip_q;
`endif
   end

   // S/R default to 0 every cycle so a pulse can only ever last the DRIVE cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         rr_ptr <= '0;
         winner <= '0;
         op_l   <= 1'b0;
         idx_l  <= '0;
         s_out  <= '0;
         r_out  <= '0;
         flag_q <= '0;
      end else begin
         s_out <= '0;
         r_out <= '0;
         if (state == IDLE && pick_valid) begin
            winner <= pick;
            op_l   <= op_sel;
            idx_l  <= idx_sel;
         end
         if (state == GRANT && !skip_now) begin
            if (op_l) s_out <= target;
            else      r_out <= target;
         end
         if (state == DRIVE) flag_q[idx_l] <= op_l;
         if (state == ACK)   rr_ptr <= next_ptr;
      end
   end

endmodule

// File: tb/tb_srff_bank_arbiter.sv
// Bench for srff_bank_arbiter: directed scenarios plus a random run against a transaction-level model.
module tb_srff_bank_arbiter;

   localparam int NREQ  = 4;
   localparam int IDX_W = 3;
   localparam int NFLAG = 8;

   logic                  clk = 1'b0;
   logic                  reset;
   logic [NREQ-1:0]       req;
   logic [NREQ-1:0]       op;
   logic [NREQ*IDX_W-1:0] idx;
   logic [NREQ-1:0]       ack;
   logic                  busy;
   logic [NFLAG-1:0]      s_out, r_out, flag_q;
   logic                  skipped;

   int n_checks = 0;
   int n_errors = 0;

   int r_req [NREQ];
   int r_op  [NREQ];
   int r_idx [NREQ];

   // Model: m_age is cycles since grant (-1 = nothing in flight); 1 = pulse cycle, 2 = ack cycle.
   int m_age = -1;
   int m_ptr = 0;
   int m_win = 0;
   int m_op  = 0;
   int m_idx = 0;
   int m_flag = 0;
   int m_skipped = 0;

   srff_bank_arbiter #(.NREQ(NREQ), .IDX_W(IDX_W)) dut (
      .clk     (clk),
      .reset   (reset),
      .req     (req),
      .op      (op),
      .idx     (idx),
      .ack     (ack),
      .busy    (busy),
      .s_out   (s_out),
      .r_out   (r_out),
      .flag_q  (flag_q),
      .skipped (skipped)
   );

   always #5 clk = ~clk;

   function automatic int rr_pick(input int r, input int p);
      for (int k = 0; k < NREQ; k++) begin
         if (((r >> ((p + k) % NREQ)) & 1) == 1) return (p + k) % NREQ;
      end
      return -1;
   endfunction

   function automatic int exp_s();
      return (m_age == 1 && m_op == 1) ? (1 << m_idx) : 0;
   endfunction

   function automatic int exp_r();
      return (m_age == 1 && m_op == 0) ? (1 << m_idx) : 0;
   endfunction

   function automatic int exp_ack();
      return (m_age == 2) ? (1 << m_win) : 0;
   endfunction

   always @(posedge clk) begin
      if (reset) begin
         m_age     <= -1;
         m_ptr     <= 0;
         m_flag    <= 0;
         m_skipped <= 0;
      end else begin
         case (m_age)
            -1: if (rr_pick(int'(req), m_ptr) >= 0) begin
               m_win <= rr_pick(int'(req), m_ptr);
               m_op  <= (int'(op) >> rr_pick(int'(req), m_ptr)) & 1;
               m_idx <= (int'(idx) >> (rr_pick(int'(req), m_ptr) * IDX_W)) & (NFLAG - 1);
               m_age <= 0;
            end
            0: begin
`ifdef SRFF_ARB_SKIP_EN
               if (((m_flag >> m_idx) & 1) == m_op) begin
                  m_age     <= 2;
                  m_skipped <= 1;
               end else begin
                  m_age     <= 1;
                  m_skipped <= 0;
               end
`else
               m_age     <= 1;
               m_skipped <= 0;
`endif
            end
            1: begin
               m_flag <= (m_op == 1) ? (m_flag | (1 << m_idx)) : (m_flag & ~(1 << m_idx));
               m_age  <= 2;
            end
            default: begin
               m_ptr <= (m_win + 1) % NREQ;
               m_age <= -1;
            end
         endcase
      end
   end

   task automatic apply();
      int rq = 0;
      int o  = 0;
      int x  = 0;
      for (int k = 0; k < NREQ; k++) begin
         rq |= (r_req[k] & 1) << k;
         o  |= (r_op[k] & 1) << k;
         x  |= (r_idx[k] & (NFLAG - 1)) << (k * IDX_W);
      end
      req = NREQ'(rq);
      op  = NREQ'(o);
      idx = (NREQ*IDX_W)'(x);
   endtask

   task automatic clear_reqs();
      for (int k = 0; k < NREQ; k++) r_req[k] = 0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      clear_reqs();
      apply();
      repeat (2) @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      for (int k = 0; k < NREQ; k++) begin
         r_req[k] = 1; r_op[k] = 1; r_idx[k] = k;
      end
      apply();
      repeat (3) @(negedge clk);
      n_checks++; if (ack !== 4'h0)    begin n_errors++; $display("FAIL reset_ack actual=%h required=0", ack); end
      n_checks++; if (busy !== 1'b0)   begin n_errors++; $display("FAIL reset_busy actual=%b required=0", busy); end
      n_checks++; if (s_out !== 8'h00) begin n_errors++; $display("FAIL reset_s_out actual=%h required=00", s_out); end
      n_checks++; if (r_out !== 8'h00) begin n_errors++; $display("FAIL reset_r_out actual=%h required=00", r_out); end
      n_checks++; if (flag_q !== 8'h00) begin n_errors++; $display("FAIL reset_flag_q actual=%h required=00", flag_q); end
      n_checks++; if (skipped !== 1'b0) begin n_errors++; $display("FAIL reset_skipped actual=%b required=0", skipped); end
      clear_reqs();
      apply();
      reset = 1'b0;
   endtask

   task automatic test_single_set();
      do_reset();
      r_req[0] = 1; r_op[0] = 1; r_idx[0] = 3;
      apply();
      @(negedge clk);
      n_checks++; if (busy !== 1'b1) begin n_errors++; $display("FAIL single_busy_n1 actual=%b required=1", busy); end
      n_checks++; if (s_out !== 8'h00) begin n_errors++; $display("FAIL single_s_n1 actual=%h required=00", s_out); end
      @(negedge clk);
      n_checks++; if (s_out !== 8'h08) begin n_errors++; $display("FAIL single_s_n2 actual=%h required=08", s_out); end
      n_checks++; if (r_out !== 8'h00) begin n_errors++; $display("FAIL single_r_n2 actual=%h required=00", r_out); end
      n_checks++; if (ack !== 4'h0) begin n_errors++; $display("FAIL single_ack_n2 actual=%h required=0", ack); end
      @(negedge clk);
      n_checks++; if (ack !== 4'b0001) begin n_errors++; $display("FAIL single_ack_n3 actual=%b required=0001", ack); end
      n_checks++; if (s_out !== 8'h00) begin n_errors++; $display("FAIL single_s_n3 actual=%h required=00", s_out); end
      n_checks++; if (flag_q !== 8'h08) begin n_errors++; $display("FAIL single_flag_n3 actual=%h required=08", flag_q); end
      clear_reqs();
      apply();
      @(negedge clk);
      n_checks++; if (ack !== 4'h0) begin n_errors++; $display("FAIL single_ack_n4 actual=%h required=0", ack); end
      n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL single_busy_n4 actual=%b required=0", busy); end
      n_checks++; if (flag_q !== 8'h08) begin n_errors++; $display("FAIL single_flag_n4 actual=%h required=08", flag_q); end
   endtask

   task automatic test_round_robin();
      int who [$];
      int when [$];
      int gap_exp;
      do_reset();
      for (int k = 0; k < NREQ; k++) begin
         r_req[k] = 1; r_op[k] = 1; r_idx[k] = k;
      end
      apply();
      for (int c = 0; c < 40 && who.size() < 5; c++) begin
         @(negedge clk);
         for (int k = 0; k < NREQ; k++) begin
            if (((int'(ack) >> k) & 1) == 1) begin
               who.push_back(k);
               when.push_back(c);
            end
         end
         if (who.size() >= 5) begin
            clear_reqs();
            apply();
         end
      end
      n_checks++;
      if (who.size() != 5) begin
         n_errors++;
         $display("FAIL rr_ack_count actual=%0d required=5", who.size());
      end else begin
         for (int k = 0; k < 5; k++) begin
            n_checks++;
            if (who[k] != k % NREQ) begin
               n_errors++;
               $display("FAIL rr_order grant%0d actual=%0d required=%0d", k, who[k], k % NREQ);
            end
         end
         for (int k = 1; k < 5; k++) begin
            gap_exp = 4;
`ifdef SRFF_ARB_SKIP_EN
            if (k == 4) gap_exp = 3;
`endif
            n_checks++;
            if (when[k] - when[k-1] != gap_exp) begin
               n_errors++;
               $display("FAIL rr_gap%0d actual=%0d required=%0d", k, when[k] - when[k-1], gap_exp);
            end
         end
      end
      repeat (2) @(negedge clk);
      n_checks++; if (flag_q !== 8'h0F) begin n_errors++; $display("FAIL rr_flag actual=%h required=0f", flag_q); end
   endtask

   task automatic test_set_clear();
      int s_cyc = -1;
      int r_cyc = -1;
      int both  = 0;
      int nacks = 0;
      do_reset();
      r_req[1] = 1; r_op[1] = 1; r_idx[1] = 5;
      r_req[2] = 1; r_op[2] = 0; r_idx[2] = 5;
      apply();
      for (int c = 0; c < 30; c++) begin
         @(negedge clk);
         if (s_out === 8'h20 && s_cyc < 0) s_cyc = c;
         if (r_out === 8'h20 && r_cyc < 0) r_cyc = c;
         if ((s_out & r_out) !== 8'h00) both = 1;
         for (int k = 0; k < NREQ; k++) begin
            if (((int'(ack) >> k) & 1) == 1) begin
               r_req[k] = 0;
               nacks++;
            end
         end
         apply();
      end
      n_checks++; if (s_cyc < 0) begin n_errors++; $display("FAIL sc_s_pulse actual=none required=20"); end
      n_checks++; if (r_cyc <= s_cyc) begin n_errors++; $display("FAIL sc_order actual_s=%0d actual_r=%0d required=r_after_s", s_cyc, r_cyc); end
      n_checks++; if (both != 0) begin n_errors++; $display("FAIL sc_overlap actual=1 required=0"); end
      n_checks++; if (nacks != 2) begin n_errors++; $display("FAIL sc_acks actual=%0d required=2", nacks); end
      n_checks++; if (flag_q !== 8'h00) begin n_errors++; $display("FAIL sc_flag actual=%h required=00", flag_q); end
   endtask

   task automatic test_reset_mid();
      int c = 0;
      int acc = 0;
      do_reset();
      r_req[0] = 1; r_op[0] = 1; r_idx[0] = 6;
      apply();
      while (c < 10 && s_out !== 8'h40) begin
         @(negedge clk);
         c++;
      end
      n_checks++;
      if (s_out !== 8'h40) begin
         n_errors++;
         $display("FAIL rm_drive_timeout actual=%h required=40", s_out);
      end
      reset = 1'b1;
      clear_reqs();
      apply();
      @(negedge clk);
      n_checks++; if (ack !== 4'h0) begin n_errors++; $display("FAIL rm_ack actual=%h required=0", ack); end
      n_checks++; if (s_out !== 8'h00 || r_out !== 8'h00) begin n_errors++; $display("FAIL rm_sr actual=%h/%h required=00/00", s_out, r_out); end
      n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL rm_busy actual=%b required=0", busy); end
      n_checks++; if (flag_q !== 8'h00) begin n_errors++; $display("FAIL rm_flag actual=%h required=00", flag_q); end
      reset = 1'b0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         acc |= int'(ack) | int'(busy);
      end
      n_checks++; if (acc != 0) begin n_errors++; $display("FAIL rm_after actual=%0d required=0", acc); end
   endtask

   task automatic test_early_withdrawal();
      int acc = 0;
      do_reset();
      r_req[1] = 1; r_op[1] = 1; r_idx[1] = 1;
      apply();
      @(negedge clk);
      n_checks++; if (busy !== 1'b1) begin n_errors++; $display("FAIL ew_busy actual=%b required=1", busy); end
      acc |= int'(ack);
      r_req[0] = 1; r_op[0] = 1; r_idx[0] = 7;
      apply();
      @(negedge clk);
      acc |= int'(ack);
      r_req[0] = 0;
      apply();
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         acc |= int'(ack);
         if (((int'(ack) >> 1) & 1) == 1) r_req[1] = 0;
         apply();
      end
      n_checks++; if (acc != 2) begin n_errors++; $display("FAIL ew_acks actual=%0d required=2", acc); end
      n_checks++; if (flag_q !== 8'h02) begin n_errors++; $display("FAIL ew_flag actual=%h required=02", flag_q); end
   endtask

`ifdef SRFF_ARB_SKIP_EN
   task automatic test_skip();
      int seen_s = 0;
      do_reset();
      r_req[2] = 1; r_op[2] = 1; r_idx[2] = 2;
      apply();
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         if (s_out === 8'h04) seen_s = 1;
         if (ack[2] === 1'b1) r_req[2] = 0;
         apply();
      end
      n_checks++; if (seen_s != 1) begin n_errors++; $display("FAIL skip_first_pulse actual=none required=04"); end
      r_req[2] = 1;
      apply();
      @(negedge clk);
      n_checks++; if (s_out !== 8'h00 || busy !== 1'b1) begin n_errors++; $display("FAIL skip_n1 actual=%h/%b required=00/1", s_out, busy); end
      @(negedge clk);
      n_checks++; if (ack !== 4'b0100) begin n_errors++; $display("FAIL skip_ack_n2 actual=%b required=0100", ack); end
      n_checks++; if (skipped !== 1'b1) begin n_errors++; $display("FAIL skip_flag_n2 actual=%b required=1", skipped); end
      n_checks++; if (s_out !== 8'h00 || r_out !== 8'h00) begin n_errors++; $display("FAIL skip_sr_n2 actual=%h/%h required=00/00", s_out, r_out); end
      clear_reqs();
      apply();
      @(negedge clk);
      n_checks++; if (skipped !== 1'b0) begin n_errors++; $display("FAIL skip_clear_n3 actual=%b required=0", skipped); end
   endtask
`endif

   task automatic test_random();
      for (int cyc = 0; cyc < 600; cyc++) begin
         @(negedge clk);
         n_checks++; if (s_out !== NFLAG'(exp_s())) begin n_errors++; $display("FAIL rand_s_out cyc=%0d actual=%h required=%h", cyc, s_out, exp_s()); end
         n_checks++; if (r_out !== NFLAG'(exp_r())) begin n_errors++; $display("FAIL rand_r_out cyc=%0d actual=%h required=%h", cyc, r_out, exp_r()); end
         n_checks++; if (ack !== NREQ'(exp_ack())) begin n_errors++; $display("FAIL rand_ack cyc=%0d actual=%h required=%h", cyc, ack, exp_ack()); end
         n_checks++; if (busy !== (m_age != -1)) begin n_errors++; $display("FAIL rand_busy cyc=%0d actual=%b required=%b", cyc, busy, m_age != -1); end
         n_checks++; if (flag_q !== NFLAG'(m_flag)) begin n_errors++; $display("FAIL rand_flag cyc=%0d actual=%h required=%h", cyc, flag_q, m_flag); end
         n_checks++; if (skipped !== (m_age == 2 && m_skipped == 1)) begin n_errors++; $display("FAIL rand_skipped cyc=%0d actual=%b", cyc, skipped); end
         n_checks++;
         if ((s_out & r_out) !== 8'h00 || $countones(s_out | r_out) > 1) begin
            n_errors++;
            $display("FAIL rand_sr_invariant cyc=%0d actual=%h/%h required=disjoint_onehot", cyc, s_out, r_out);
         end
         if (reset) begin
            reset = 1'b0;
         end else if ($urandom_range(0, 149) == 0) begin
            reset = 1'b1;
            clear_reqs();
         end else begin
            for (int k = 0; k < NREQ; k++) begin
               if (r_req[k] == 1 && ((int'(ack) >> k) & 1) == 1) begin
                  r_req[k] = ($urandom_range(0, 3) == 0) ? 1 : 0;
               end else if (r_req[k] == 0 && $urandom_range(0, 2) == 0) begin
                  r_req[k] = 1;
                  r_op[k]  = int'($urandom_range(0, 1));
                  r_idx[k] = int'($urandom_range(0, NFLAG - 1));
               end
            end
         end
         apply();
      end
      reset = 1'b0;
      clear_reqs();
      apply();
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int k = 0; k < NREQ; k++) begin
         r_req[k] = 0; r_op[k] = 0; r_idx[k] = 0;
      end
      reset = 1'b1;
      apply();
      test_reset();
      test_single_set();
      test_round_robin();
      test_set_clear();
      test_reset_mid();
      test_early_withdrawal();
`ifdef SRFF_ARB_SKIP_EN
      test_skip();
`endif
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
